// File: rtl/rct_bus_pkg.sv
// Shared types and constants for the management-bus to CSR-bus bridge.
package rct_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } csr_state_e;

    localparam logic [31:0] CSR_ERR_DATA  = 32'hDEAD_BEEF;
    localparam int unsigned CSR_AW        = 18;
    localparam int unsigned CSR_TMR_W     = 8;
    localparam int unsigned CSR_CNT_W     = 8;
    localparam logic [31:0] CSR_BASE_ADDR = 32'h3000_0000;
    localparam logic [31:0] CSR_ADDR_MASK = 32'hFFF0_0000;
    localparam int unsigned CSR_TIMEOUT   = 64;

endpackage

// File: rtl/rct_wb_csr_bridge.sv
// Wishbone classic slave bridging to a single-outstanding CSR bus; every access
// is acknowledged (window misses and CSR timeouts included) so the master never hangs.
module rct_wb_csr_bridge
    import rct_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = CSR_BASE_ADDR,
    parameter logic [31:0] ADDR_MASK = CSR_ADDR_MASK,
    parameter int unsigned TIMEOUT   = CSR_TIMEOUT
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              csr_req_o,
    output logic              csr_we_o,
    output logic [CSR_AW-1:0] csr_addr_o,
    output logic [3:0]        csr_be_o,
    output logic [31:0]       csr_wdata_o,
    input  logic              csr_rdy_i,
    input  logic [31:0]       csr_rdata_i,
    output logic              err_o,
    input  logic              err_clr_i,
    output logic [7:0]        timeout_cnt_o
);

    localparam logic [CSR_TMR_W-1:0] TMR_LAST = CSR_TMR_W'(TIMEOUT - 1);
    localparam logic [CSR_CNT_W-1:0] CNT_MAX  = '1;

    csr_state_e           r_state, w_state_nxt;
    logic [CSR_TMR_W-1:0] r_timer, w_timer_nxt;
    logic [CSR_CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic                 r_ack,   w_ack_nxt;
    logic [31:0]          r_dat,   w_dat_nxt;
    logic                 r_req,   w_req_nxt;
    logic                 r_we,    w_we_nxt;
    logic [CSR_AW-1:0]    r_addr,  w_addr_nxt;
    logic [3:0]           r_be,    w_be_nxt;
    logic [31:0]          r_wdata, w_wdata_nxt;
    logic                 r_err,   w_err_nxt;
    logic                 w_hit;

    assign w_hit = (wbs_adr_i & ADDR_MASK) == BASE_ADDR;

    // Next-state and next-output logic; everything holds unless a rule fires.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_cnt_nxt   = r_cnt;
        w_dat_nxt   = r_dat;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_be_nxt    = r_be;
        w_wdata_nxt = r_wdata;
        w_err_nxt   = r_err & ~err_clr_i;

        unique case (r_state)
            ST_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    if (w_hit) begin
                        w_we_nxt    = wbs_we_i;
                        w_addr_nxt  = wbs_adr_i[CSR_AW+1:2];
                        w_be_nxt    = wbs_sel_i;
                        w_wdata_nxt = wbs_dat_i;
                        w_timer_nxt = '0;
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_dat_nxt   = '0;
                        w_state_nxt = ST_RESP;
                    end
                end
            end
            ST_REQ: begin
                if (csr_rdy_i) begin
                    w_dat_nxt   = r_we ? 32'h0 : csr_rdata_i;
                    w_state_nxt = ST_RESP;
                end else if (r_timer == TMR_LAST) begin
                    w_dat_nxt   = CSR_ERR_DATA;
                    w_err_nxt   = 1'b1;
                    w_cnt_nxt   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CSR_CNT_W'(1);
                    w_state_nxt = ST_RESP;
                end else begin
                    w_timer_nxt = r_timer + CSR_TMR_W'(1);
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase

        // Ack is gated by cyc at the end of the last pre-RESP cycle, so an aborted access is silent.
        w_req_nxt = (w_state_nxt == ST_REQ);
        w_ack_nxt = (w_state_nxt == ST_RESP) && wbs_cyc_i;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_dat   <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= w_ack_nxt;
            r_dat   <= w_dat_nxt;
            r_req   <= w_req_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_be    <= w_be_nxt;
            r_wdata <= w_wdata_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign wbs_ack_o     = r_ack;
    assign wbs_dat_o     = r_dat;
    assign csr_req_o     = r_req;
    assign csr_we_o      = r_we;
    assign csr_addr_o    = r_addr;
    assign csr_be_o      = r_be;
    assign csr_wdata_o   = r_wdata;
    assign err_o         = r_err;
    assign timeout_cnt_o = r_cnt;

endmodule

// File: tb/tb_rct_wb_csr_bridge.sv
// Bench for rct_wb_csr_bridge: transaction-level model of the bridge timing rules,
// compared against every DUT output on each falling clock edge.
module tb_rct_wb_csr_bridge;

    localparam int          TO   = 64;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] MASK = 32'hFFF0_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = '0;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        csr_req_o, csr_we_o;
    logic [17:0] csr_addr_o;
    logic [3:0]  csr_be_o;
    logic [31:0] csr_wdata_o;
    logic        csr_rdy_i = 1'b0;
    logic [31:0] csr_rdata_i = '0;
    logic        err_o;
    logic        err_clr_i = 1'b0;
    logic [7:0]  timeout_cnt_o;

    // Model of the expected DUT outputs in the current cycle.
    logic        m_ack = 0, m_req = 0, m_we = 0, m_err = 0;
    logic [31:0] m_dat = 0, m_wdata = 0;
    logic [17:0] m_addr = 0;
    logic [3:0]  m_be = 0;
    logic [7:0]  m_cnt = 0;

    int n_cmp = 0;
    int n_bad = 0;

    rct_wb_csr_bridge dut (
        .wb_clk_i      (clk),
        .wb_rst_n_i    (rst_n),
        .wbs_cyc_i     (wbs_cyc_i),
        .wbs_stb_i     (wbs_stb_i),
        .wbs_we_i      (wbs_we_i),
        .wbs_sel_i     (wbs_sel_i),
        .wbs_adr_i     (wbs_adr_i),
        .wbs_dat_i     (wbs_dat_i),
        .wbs_ack_o     (wbs_ack_o),
        .wbs_dat_o     (wbs_dat_o),
        .csr_req_o     (csr_req_o),
        .csr_we_o      (csr_we_o),
        .csr_addr_o    (csr_addr_o),
        .csr_be_o      (csr_be_o),
        .csr_wdata_o   (csr_wdata_o),
        .csr_rdy_i     (csr_rdy_i),
        .csr_rdata_i   (csr_rdata_i),
        .err_o         (err_o),
        .err_clr_i     (err_clr_i),
        .timeout_cnt_o (timeout_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cmp("ack",   32'(wbs_ack_o),     32'(m_ack));
        cmp("dat",   wbs_dat_o,          m_dat);
        cmp("req",   32'(csr_req_o),     32'(m_req));
        cmp("we",    32'(csr_we_o),      32'(m_we));
        cmp("addr",  32'(csr_addr_o),    32'(m_addr));
        cmp("be",    32'(csr_be_o),      32'(m_be));
        cmp("wdata", csr_wdata_o,        m_wdata);
        cmp("err",   32'(err_o),         32'(m_err));
        cmp("tocnt", 32'(timeout_cnt_o), 32'(m_cnt));
    end

    // One Wishbone access, cycle 0 = the cycle the strobe is first sampled.
    // k: CSR wait cycles before rdy (k >= TO never answers); drop_at: cycle cyc falls (0 = never);
    // clr_at: cycle err_clr_i is pulsed (-1 = never). Starts and ends just after a rising edge.
    task automatic access(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] wd, input logic [31:0] rd, input int k,
                          input int drop_at, input int clr_at,
                          output int ack_at, output int nacks, output int nreq);
        logic hit, tmo, dropped;
        int   last_req, resp;
        hit      = (adr & MASK) == BASE;
        tmo      = hit && (k >= TO);
        last_req = !hit ? 0 : (tmo ? TO : 1 + k);
        resp     = !hit ? 1 : last_req + 1;
        ack_at = -1; nacks = 0; nreq = 0;
        wbs_we_i = we; wbs_adr_i = adr; wbs_sel_i = sel; wbs_dat_i = wd;
        for (int n = 0; n <= resp; n++) begin
            if (n >= 1) begin
                if (tmo && n == resp) begin
                    m_err = 1'b1;
                    if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
                end else if (clr_at == n - 1) begin
                    m_err = 1'b0;
                end
            end
            dropped     = (drop_at > 0) && (n >= drop_at);
            wbs_cyc_i   = !dropped;
            wbs_stb_i   = !dropped;
            err_clr_i   = (n == clr_at);
            csr_rdy_i   = hit && !tmo && (n == 1 + k);
            csr_rdata_i = csr_rdy_i ? rd : $urandom;
            if (hit && n == 1) begin
                m_we = we; m_addr = adr[19:2]; m_be = sel; m_wdata = wd;
            end
            m_req = hit && (n >= 1) && (n <= last_req);
            m_ack = (n == resp) && (drop_at == 0);
            if (n == resp) m_dat = !hit ? 32'h0 : tmo ? 32'hDEAD_BEEF : we ? 32'h0 : rd;
            @(negedge clk);
            if (wbs_ack_o) begin
                nacks++;
                if (ack_at < 0) ack_at = n;
            end
            if (csr_req_o) nreq++;
            @(posedge clk); #1;
        end
        if (clr_at == resp) m_err = 1'b0;
        m_ack = 1'b0; m_req = 1'b0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; err_clr_i = 1'b0; csr_rdy_i = 1'b0;
    endtask

    task automatic idle(input int cycles, input logic clr_first);
        for (int i = 0; i < cycles; i++) begin
            wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
            err_clr_i = clr_first && (i == 0);
            @(posedge clk); #1;
            if (clr_first && i == 0) m_err = 1'b0;
        end
        err_clr_i = 1'b0;
    endtask

    function automatic logic [31:0] rand_adr(input logic hit);
        logic [31:0] a;
        a = $urandom;
        if (hit) a = BASE | (a & ~MASK);
        else if ((a & MASK) == BASE) a = a ^ 32'h8000_0000;
        return a;
    endfunction

    initial begin
        int a, na, nr, k, drop, clr, lr;
        logic hit, we;

        repeat (3) @(posedge clk);
        #1;
        cmp("rst_ack", 32'(wbs_ack_o), 32'h0);
        cmp("rst_req", 32'(csr_req_o), 32'h0);
        cmp("rst_dat", wbs_dat_o,      32'h0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        access(1'b1, 32'h3000_0010, 4'b0011, 32'h1234_5678, 32'h0, 0, 0, -1, a, na, nr);
        cmp("wr_ack_lat", 32'(a),          32'd2);
        cmp("wr_nacks",   32'(na),         32'd1);
        cmp("wr_addr",    32'(csr_addr_o), 32'h4);
        cmp("wr_be",      32'(csr_be_o),   32'h3);
        cmp("wr_wdata",   csr_wdata_o,     32'h1234_5678);

        access(1'b0, 32'h3000_0004, 4'hF, 32'h0, 32'hCAFE_0001, 3, 0, -1, a, na, nr);
        cmp("rd_ack_lat", 32'(a),  32'd5);
        cmp("rd_dat",     wbs_dat_o, 32'hCAFE_0001);

        access(1'b0, 32'h2000_0000, 4'hF, 32'h0, 32'h0, 0, 0, -1, a, na, nr);
        cmp("miss_ack_lat", 32'(a),  32'd1);
        cmp("miss_nreq",    32'(nr), 32'd0);
        cmp("miss_dat",     wbs_dat_o, 32'h0);

        access(1'b0, 32'h3000_0100, 4'hF, 32'h0, 32'h0, TO, 0, -1, a, na, nr);
        cmp("to_nreq",    32'(nr),            32'd64);
        cmp("to_ack_lat", 32'(a),             32'd65);
        cmp("to_dat",     wbs_dat_o,          32'hDEAD_BEEF);
        cmp("to_err",     32'(err_o),         32'h1);
        cmp("to_cnt",     32'(timeout_cnt_o), 32'h1);

        access(1'b0, 32'h3000_0200, 4'hF, 32'h0, 32'h5555_AAAA, 4, 2, -1, a, na, nr);
        cmp("abort_nacks", 32'(na), 32'd0);
        access(1'b1, 32'h3000_0204, 4'hC, 32'h0BAD_F00D, 32'h0, 0, 0, -1, a, na, nr);
        cmp("post_abort_lat", 32'(a), 32'd2);

        for (int t = 0; t < 60; t++) begin
            hit  = ($urandom_range(0, 3) != 0);
            we   = $urandom_range(0, 1);
            k    = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 4);
            lr   = !hit ? 0 : (k >= TO ? TO : 1 + k);
            drop = (hit && $urandom_range(0, 6) == 0) ? $urandom_range(1, lr) : 0;
            clr  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, lr + 1) : -1;
            access(we, rand_adr(hit), 4'($urandom), $urandom, $urandom, k, drop, clr, a, na, nr);
            idle($urandom_range(0, 2), $urandom_range(0, 3) == 0);
        end

        for (int t = 0; t < 300; t++)
            access(1'b0, rand_adr(1'b1), 4'hF, 32'h0, 32'h0, TO, 0, -1, a, na, nr);
        cmp("sat_cnt", 32'(timeout_cnt_o), 32'd255);

        // Reset in the middle of a pending CSR request.
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = 32'h3000_0040; wbs_sel_i = 4'hF; wbs_dat_i = 32'h0;
        @(posedge clk); #1;
        m_we = 1'b0; m_addr = 18'h10; m_be = 4'hF; m_wdata = 32'h0; m_req = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        #2;
        m_ack = 0; m_req = 0; m_we = 0; m_err = 0; m_dat = 0; m_wdata = 0;
        m_addr = 0; m_be = 0; m_cnt = 0;
        rst_n = 1'b0;
        #1;
        cmp("arst_req", 32'(csr_req_o),     32'h0);
        cmp("arst_ack", 32'(wbs_ack_o),     32'h0);
        cmp("arst_err", 32'(err_o),         32'h0);
        cmp("arst_cnt", 32'(timeout_cnt_o), 32'h0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        access(1'b0, 32'h3000_0008, 4'hF, 32'h0, 32'h0000_7777, 0, 0, -1, a, na, nr);
        cmp("post_rst_lat", 32'(a), 32'd2);

        access(1'b0, 32'h3000_000C, 4'hF, 32'h0, 32'h0, TO, 0, TO, a, na, nr);
        cmp("set_wins_err", 32'(err_o), 32'h1);
        idle(2, 1'b1);
        cmp("clr_err", 32'(err_o), 32'h0);
        idle(2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
